// File: rtl/tdr_shot_ctrl.sv
// rtl/tdr_shot_ctrl.sv - TDR shot controller: launch pulse, echo timing, settle, result handshake.
// Define TDR_AVG_EN to average 2^AVG_LOG2 shots per measurement.
module tdr_shot_ctrl #(
    parameter int PULSE_W  = 4,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 255,
    parameter int SETTLE   = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             pulse_out,
    input  logic             echo_in,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] result_delay,
    output logic             result_timeout
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_LISTEN = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

`ifdef TDR_AVG_EN
    localparam bit AVG_ON = 1'b1;
`else
    localparam bit AVG_ON = 1'b0;
`endif
    localparam int NUM_SHOTS = AVG_ON ? (1 << AVG_LOG2) : 1;

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             to_flag;
    logic             listen_end;
    logic             settle_end;
    logic             last_shot;
    logic [CNT_W-1:0] result_value;

    // A shot ends on the first echo or at TIMEOUT; the echo takes priority.
    assign listen_end = (state == S_LISTEN) && !abort && (echo_in || (cnt == TIMEOUT_C));
    assign settle_end = (state == S_SETTLE) && !abort && (settle_cnt == SETTLE_LAST);

`ifdef TDR_AVG_EN
    localparam int SHOT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W  = CNT_W + AVG_LOG2;

    logic [SHOT_W-1:0] shot_cnt;
    logic [ACC_W-1:0]  acc;

    assign last_shot    = (shot_cnt == SHOT_W'(NUM_SHOTS - 1));
    assign result_value = acc[ACC_W-1:AVG_LOG2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shot_cnt <= '0;
            acc      <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                shot_cnt <= '0;
                acc      <= '0;
            end else if (listen_end) begin
                acc <= acc + ACC_W'(cnt);
            end else if (settle_end && !last_shot) begin
                shot_cnt <= shot_cnt + SHOT_W'(1);
            end
        end
    end
`else
    logic [CNT_W-1:0] shot_delay;

    assign last_shot    = (NUM_SHOTS == 1);
    assign result_value = shot_delay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shot_delay <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                shot_delay <= '0;
            end else if (listen_end) begin
                shot_delay <= cnt;
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (abort)                    state_nxt = S_IDLE;
                else if (cnt == PULSE_LAST)   state_nxt = S_LISTEN;
            end
            S_LISTEN: begin
                if (abort)                    state_nxt = S_IDLE;
                else if (listen_end)          state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)                    state_nxt = S_IDLE;
                else if (settle_end)          state_nxt = last_shot ? S_DONE : S_LAUNCH;
            end
            S_DONE: begin
                if (result_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            settle_cnt     <= '0;
            to_flag        <= 1'b0;
            pulse_out      <= 1'b0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_delay   <= '0;
            result_timeout <= 1'b0;
        end else begin
            state        <= state_nxt;
            pulse_out    <= (state_nxt == S_LAUNCH);
            busy         <= (state_nxt != S_IDLE);
            result_valid <= (state_nxt == S_DONE);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        to_flag <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_LISTEN: begin
                    if (listen_end) begin
                        settle_cnt <= '0;
                        if (!echo_in) to_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    if (settle_end) cnt <= '0;
                end
                default: ;
            endcase

            if ((state == S_SETTLE) && (state_nxt == S_DONE)) begin
                result_delay   <= result_value;
                result_timeout <= to_flag;
            end
        end
    end

endmodule

// File: tb/tb_tdr_shot_ctrl.sv
// tb/tb_tdr_shot_ctrl.sv - randomized self-checking bench for tdr_shot_ctrl.
module tb_tdr_shot_ctrl;

    localparam int PULSE_W  = 4;
    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 255;
    localparam int SETTLE   = 16;
    localparam int AVG_LOG2 = 2;
`ifdef TDR_AVG_EN
    localparam int SHOTS = 1 << AVG_LOG2;
`else
    localparam int SHOTS = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             pulse_out;
    logic             echo_in;
    logic             busy;
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] result_delay;
    logic             result_timeout;

    int checks   = 0;
    int failures = 0;

    int cyc        = 0;
    int rise       = 0;
    int shots_seen = 0;
    int hi_cnt     = 0;
    bit prev_pulse = 1'b0;

    int echo_k   [SHOTS];
    int echo_len [SHOTS];
    int exp_d    [SHOTS];
    int exp_delay;
    bit exp_timeout;

    tdr_shot_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .pulse_out      (pulse_out),
        .echo_in        (echo_in),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_delay   (result_delay),
        .result_timeout (result_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Line model: shot i reflects an echo on offsets [k, k+len) after its pulse rises.
    task automatic step();
        int idx;
        int off;
        @(negedge clk);
        cyc++;
        if (pulse_out && !prev_pulse) begin
            if (shots_seen > 0 && shots_seen <= SHOTS)
                check_eq("shot_gap", cyc - rise, exp_d[shots_seen-1] + 1 + SETTLE);
            rise = cyc;
            shots_seen++;
            hi_cnt = 0;
        end
        if (pulse_out) hi_cnt++;
        else if (prev_pulse) check_eq("pulse_width", hi_cnt, PULSE_W);
        prev_pulse = pulse_out;
        idx = shots_seen - 1;
        off = cyc - rise;
        if (idx >= 0 && idx < SHOTS)
            echo_in = (off >= echo_k[idx]) && (off < echo_k[idx] + echo_len[idx]);
        else
            echo_in = 1'b0;
    endtask

    // Shot delay is the first visible echo offset at or after the pulse, else TIMEOUT.
    task automatic shot_model(input int k, input int len, output int d, output bit to);
        int first;
        first = (k > PULSE_W) ? k : PULSE_W;
        if ((k + len - 1 < PULSE_W) || (first > TIMEOUT)) begin
            d  = TIMEOUT;
            to = 1'b1;
        end else begin
            d  = first;
            to = 1'b0;
        end
    endtask

    task automatic plan(input int mode);
        int sum;
        int d;
        bit to;
        int r;
        sum = 0;
        exp_timeout = 1'b0;
        for (int i = 0; i < SHOTS; i++) begin
            case (mode)
                0: begin
                    r = $urandom_range(0, 9);
                    case (r)
                        0: begin echo_k[i] = PULSE_W - 1; echo_len[i] = 1; end
                        1: begin echo_k[i] = PULSE_W;     echo_len[i] = 1; end
                        2: begin echo_k[i] = TIMEOUT;     echo_len[i] = 1; end
                        3: begin echo_k[i] = TIMEOUT + 1; echo_len[i] = 3; end
                        4: begin echo_k[i] = 0; echo_len[i] = $urandom_range(1, PULSE_W + 3); end
                        default: begin
                            echo_k[i]   = $urandom_range(PULSE_W, TIMEOUT - 1);
                            echo_len[i] = $urandom_range(1, 6);
                        end
                    endcase
                end
                1: begin echo_k[i] = 64;     echo_len[i] = PULSE_W; end
                2: begin echo_k[i] = 100000; echo_len[i] = 1; end
                default: begin echo_k[i] = (i == 3) ? 64 : 60 + i; echo_len[i] = 1; end
            endcase
            shot_model(echo_k[i], echo_len[i], d, to);
            exp_d[i] = d;
            sum += d;
            if (to) exp_timeout = 1'b1;
        end
        exp_delay = sum >> $clog2(SHOTS);
    endtask

    task automatic run_meas(input int hold);
        int n;
        int bound;
        bound = (PULSE_W + TIMEOUT + SETTLE + 4) * SHOTS + 20;
        shots_seen = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        n = 0;
        while (!result_valid && n < bound) begin
            start = ($urandom_range(0, 3) == 0);
            step();
            n++;
        end
        start = 1'b0;
        check_eq("done_reached", result_valid, 1);
        check_eq("shot_count", shots_seen, SHOTS);
        check_eq("done_latency", cyc - rise, exp_d[SHOTS-1] + 1 + SETTLE);
        check_eq("result_delay", result_delay, exp_delay);
        check_eq("result_timeout", result_timeout, exp_timeout);
        for (int i = 0; i < hold; i++) begin
            abort = $urandom_range(0, 1);
            step();
            check_eq("hold_valid", result_valid, 1);
            check_eq("hold_delay", result_delay, exp_delay);
            check_eq("hold_timeout", result_timeout, exp_timeout);
        end
        abort        = 1'b0;
        result_ready = 1'b1;
        start        = 1'b1;
        step();
        result_ready = 1'b0;
        start        = 1'b0;
        check_eq("handshake_valid_drop", result_valid, 0);
        check_eq("handshake_idle", busy, 0);
        step();
        check_eq("start_in_handshake_ignored", busy, 0);
        check_eq("idle_pulse", pulse_out, 0);
    endtask

    task automatic run_abort();
        int n;
        for (int i = 0; i < SHOTS; i++) begin
            echo_k[i]   = 100000;
            echo_len[i] = 1;
            exp_d[i]    = TIMEOUT;
        end
        shots_seen = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while ((cyc - rise) != 30 && n < 100) begin
            step();
            n++;
        end
        check_eq("abort_reach_cnt30", cyc - rise, 30);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_pulse", pulse_out, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("abort_no_result", result_valid, 0);
        end
    endtask

    task automatic run_reset();
        plan(0);
        shots_seen = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("rst_pulse_before", pulse_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_pulse", pulse_out, 0);
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_valid", result_valid, 0);
        check_eq("rst_async_delay", result_delay, 0);
        check_eq("rst_async_timeout", result_timeout, 0);
        prev_pulse = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check_eq("rst_release_idle", busy, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        echo_in      = 1'b0;
        result_ready = 1'b0;
        step();
        step();
        check_eq("reset_pulse", pulse_out, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_valid", result_valid, 0);
        check_eq("reset_delay", result_delay, 0);
        check_eq("reset_timeout", result_timeout, 0);
        rst_n = 1'b1;
        step();

        plan(1);
        run_meas(2);
        plan(2);
        run_meas(10);
`ifdef TDR_AVG_EN
        plan(3);
        run_meas(1);
`endif
        run_abort();
        plan(0);
        run_meas(1);
        for (int t = 0; t < 8; t++) begin
            plan(0);
            run_meas($urandom_range(0, 6));
        end
        run_reset();
        plan(0);
        run_meas(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
